// File: rtl/ipml_fifo_frame_reader.sv
`default_nettype none
// ============================================================================
// ipml_fifo_frame_reader
// Drains FRAME_LEN words from the sample FIFO into a header-led valid/ready frame.
// Rev 1.0
// ============================================================================
module ipml_fifo_frame_reader #(
  parameter int         DATA_WIDTH = 32,
  parameter int         FRAME_LEN  = 256,
  parameter int         RD_LATENCY = 1,
  parameter logic [7:0] HDR_TAG    = 8'hA5
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_PAY  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [16:0] LEN      = 17'(FRAME_LEN);
  localparam logic [16:0] LAST_IDX = 17'(FRAME_LEN - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] buf_q [4];
  logic [DATA_WIDTH-1:0] buf_d [4];
  logic [1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]            occ_q, occ_d;
  logic [RD_LATENCY-1:0] pipe_q, pipe_d;
  logic [16:0]           req_cnt_q, req_cnt_d, beat_cnt_q, beat_cnt_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  busy_q, busy_d, frame_done_q, frame_done_d;

  logic                  in_hdr, in_pay, buf_nonempty, push, pop, payload_last;
  logic [2:0]            in_flight;
  logic [DATA_WIDTH-1:0] hdr_word;

  // Reads issued but not yet landed in the buffer; reserves their slots.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      in_flight = in_flight + 3'(pipe_q[i]);
    end
  end

  always_comb begin
    in_hdr       = (state_q == S_HDR);
    in_pay       = (state_q == S_PAY);
    buf_nonempty = (occ_q != 3'd0);
    payload_last = (beat_cnt_q == LAST_IDX);
    fifo_rd_en   = (in_hdr || in_pay) && !fifo_rd_empty && (req_cnt_q < LEN)
                   && (({1'b0, occ_q} + {1'b0, in_flight}) < 4'd4);
    push         = pipe_q[RD_LATENCY-1];
    pop          = in_pay && buf_nonempty && m_ready;

    hdr_word                    = '0;
    hdr_word[DATA_WIDTH-1 -: 8] = HDR_TAG;
    hdr_word[15:0]              = frame_cnt_q;

    m_valid = in_hdr || (in_pay && buf_nonempty);
    m_last  = in_pay && buf_nonempty && payload_last;
    if (in_hdr) begin
      m_data = hdr_word;
    end else if (in_pay) begin
      m_data = buf_q[rd_ptr_q];
    end else begin
      m_data = '0;
    end
  end

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    req_cnt_d    = req_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    pipe_d       = RD_LATENCY'({pipe_q, fifo_rd_en});

    if (push) begin
      buf_d[wr_ptr_q] = fifo_rd_data;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + 2'd1;
      beat_cnt_d = beat_cnt_q + 17'd1;
    end
    occ_d = occ_q + 3'(push) - 3'(pop);
    if (fifo_rd_en) begin
      req_cnt_d = req_cnt_q + 17'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_HDR;
          busy_d     = 1'b1;
          req_cnt_d  = '0;
          beat_cnt_d = '0;
        end
      end
      S_HDR: begin
        if (m_ready) begin
          state_d = S_PAY;
        end
      end
      S_PAY: begin
        if (pop && payload_last) begin
          state_d      = S_DONE;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < 4; i++) buf_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      pipe_q       <= '0;
      req_cnt_q    <= '0;
      beat_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      for (int i = 0; i < 4; i++) buf_q[i] <= buf_d[i];
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      pipe_q       <= pipe_d;
      req_cnt_q    <= req_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
`default_nettype wire
